// File: rtl/aes32_if.sv
// Request/result handshake bundle between the issue stage, aes32_unit and writeback.
interface aes32_if #(
    parameter int unsigned TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [1:0]       in_bs;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_op, in_bs, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_bs, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/aes32_unit.sv
// Two-stage execution unit for aes32esi/esmi/dsi/dsmi: S-box in stage 1,
// MixColumn partial product, rotate and rs1 XOR in stage 2.

module aes_sbox (
    input  logic       sub,
    input  logic       inv,
    input  logic [7:0] a,
    output logic [7:0] y_c
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] e3, e7, e15, e31, e63, e127;
        e3   = gf_mul(gf_mul(x, x), x);
        e7   = gf_mul(gf_mul(e3, e3), x);
        e15  = gf_mul(gf_mul(e7, e7), x);
        e31  = gf_mul(gf_mul(e15, e15), x);
        e63  = gf_mul(gf_mul(e31, e31), x);
        e127 = gf_mul(gf_mul(e63, e63), x);
        return gf_mul(e127, e127);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    always_comb begin
        y_c = a;
        if (sub) begin
            y_c = inv ? gf_inv(inv_affine(a)) : affine(gf_inv(a));
        end
    end
endmodule

module aes32_unit #(
    parameter int unsigned TAG_W = 5
) (
    input logic   clk,
    input logic   rst_n,
    aes32_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned BYTE = 8;

    logic             s1_valid, s1_valid_nxt;
    logic             s2_valid, s2_valid_nxt;
    logic [BYTE-1:0]  s1_so;
    logic [XLEN-1:0]  s1_rs1;
    logic [1:0]       s1_bs;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;

    logic             s2_free_c;
    logic             accept_c;
    logic             advance_c;
    logic [BYTE-1:0]  byte_c;
    logic [BYTE-1:0]  sbox_c;
    logic [BYTE-1:0]  m2_c, m4_c, m8_c;
    logic [XLEN-1:0]  mix_c;
    logic [XLEN-1:0]  rot_c;

    // Handshake: in_ready never looks at in_valid.
    always_comb begin
        s2_free_c    = !s2_valid || bus.out_ready;
        bus.in_ready = !bus.flush && (!s1_valid || s2_free_c);
        accept_c     = bus.in_valid && bus.in_ready;
        advance_c    = s1_valid && s2_free_c;
    end

    always_comb begin
        s1_valid_nxt = s1_valid;
        s2_valid_nxt = s2_valid;
        if (bus.flush) begin
            s1_valid_nxt = 1'b0;
            s2_valid_nxt = 1'b0;
        end else begin
            if (accept_c) begin
                s1_valid_nxt = 1'b1;
            end else if (advance_c) begin
                s1_valid_nxt = 1'b0;
            end
            if (advance_c) begin
                s2_valid_nxt = 1'b1;
            end else if (bus.out_ready) begin
                s2_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= s1_valid_nxt;
            s2_valid <= s2_valid_nxt;
        end
    end

    // Stage 1: byte select and S-box lookup.
    always_comb begin
        byte_c = bus.in_rs2[7:0];
        case (bus.in_bs)
            2'd0: byte_c = bus.in_rs2[7:0];
            2'd1: byte_c = bus.in_rs2[15:8];
            2'd2: byte_c = bus.in_rs2[23:16];
            2'd3: byte_c = bus.in_rs2[31:24];
            default: byte_c = bus.in_rs2[7:0];
        endcase
    end

    aes_sbox u_sbox (
        .sub (1'b1),
        .inv (bus.in_op[1]),
        .a   (byte_c),
        .y_c (sbox_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_so  <= '0;
            s1_rs1 <= '0;
            s1_bs  <= '0;
            s1_op  <= '0;
            s1_tag <= '0;
        end else if (accept_c) begin
            s1_so  <= sbox_c;
            s1_rs1 <= bus.in_rs1;
            s1_bs  <= bus.in_bs;
            s1_op  <= bus.in_op;
            s1_tag <= bus.in_tag;
        end
    end

    // Stage 2: xtime chain for the 02/03 and 09/0B/0D/0E coefficients.
    always_comb begin
        m2_c = {s1_so[6:0], 1'b0} ^ (s1_so[7] ? 8'h1B : 8'h00);
        m4_c = {m2_c[6:0], 1'b0} ^ (m2_c[7] ? 8'h1B : 8'h00);
        m8_c = {m4_c[6:0], 1'b0} ^ (m4_c[7] ? 8'h1B : 8'h00);
        mix_c = {24'h000000, s1_so};
        case (s1_op)
            2'd1: mix_c = {m2_c ^ s1_so, s1_so, s1_so, m2_c};
            2'd3: mix_c = {m8_c ^ m2_c ^ s1_so, m8_c ^ m4_c ^ s1_so,
                           m8_c ^ s1_so, m8_c ^ m4_c ^ m2_c};
            default: mix_c = {24'h000000, s1_so};
        endcase
    end

    always_comb begin
        rot_c = mix_c;
        case (s1_bs)
            2'd0: rot_c = mix_c;
            2'd1: rot_c = {mix_c[23:0], mix_c[31:24]};
            2'd2: rot_c = {mix_c[15:0], mix_c[31:16]};
            2'd3: rot_c = {mix_c[7:0],  mix_c[31:8]};
            default: rot_c = mix_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            tag_q    <= '0;
        end else if (advance_c) begin
            result_q <= s1_rs1 ^ rot_c;
            tag_q    <= s1_tag;
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;
endmodule
